// File: rtl/bsg_fsb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bsg_fsb_pkg
// Description : Shared front-side-bus packet definitions used by the FSB
//               node clients and the output arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package bsg_fsb_pkg;

    localparam int FSB_DESTID_W = 4;
    localparam int FSB_DATA_W   = 75;

    // One client packet on the front-side bus: destination, command flag, payload.
    typedef struct packed {
        logic [FSB_DESTID_W-1:0] destid;
        logic                    cmd;
        logic [FSB_DATA_W-1:0]   data;
    } bsg_fsb_pkt_client_s;

endpackage : bsg_fsb_pkg
`default_nettype wire

// File: rtl/bsg_rocket_fsb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : bsg_rocket_fsb_rr_pick
// Description : Combinational rotating-priority picker. Returns the first
//               eligible client found scanning upward from start_i, wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module bsg_rocket_fsb_rr_pick
    import bsg_fsb_pkg::*;
#(
    parameter int num_clients_p = 2
) (
    input  logic [num_clients_p-1:0]         elig_i,
    input  logic [$clog2(num_clients_p)-1:0] start_i,
    output logic [num_clients_p-1:0]         grant_oh_o,
    output logic                             grant_v_o
);

    localparam int ID_W = $clog2(num_clients_p);

    logic [ID_W:0]   sum;
    logic [ID_W-1:0] idx;

    // Scan clients in order start, start+1, ... (mod N); first eligible wins.
    always_comb begin
        grant_oh_o = '0;
        grant_v_o  = 1'b0;
        sum        = '0;
        idx        = '0;
        for (int i = 0; i < num_clients_p; i++) begin
            // start_i < N and i < N, so one conditional subtract folds the wrap.
            sum = {1'b0, start_i} + (ID_W+1)'(i);
            if (sum >= (ID_W+1)'(num_clients_p)) begin
                sum = sum - (ID_W+1)'(num_clients_p);
            end
            idx = sum[ID_W-1:0];
            if (!grant_v_o && elig_i[idx]) begin
                grant_oh_o[idx] = 1'b1;
                grant_v_o       = 1'b1;
            end
        end
    end

endmodule : bsg_rocket_fsb_rr_pick
`default_nettype wire

// File: rtl/bsg_rocket_fsb_out_arb.sv
`default_nettype none
// ============================================================================
// Module      : bsg_rocket_fsb_out_arb
// Description : Merges several FSB client output streams into one registered
//               output, with round-robin arbitration and bounded bursts.
// Revision    : 1.0 - initial release
// ============================================================================
module bsg_rocket_fsb_out_arb
    import bsg_fsb_pkg::*;
#(
    parameter int num_clients_p = 2,
    parameter int burst_len_p   = 4
) (
    input  logic                                    clk_i,
    input  logic                                    reset_i,
    input  logic [num_clients_p-1:0]                en_i,
    input  logic [num_clients_p-1:0]                v_i,
    input  bsg_fsb_pkt_client_s [num_clients_p-1:0] data_i,
    output logic [num_clients_p-1:0]                yumi_o,
    output logic                                    v_o,
    output bsg_fsb_pkt_client_s                     data_o,
    input  logic                                    yumi_i
);

    localparam int ID_W    = $clog2(num_clients_p);
    localparam int BURST_W = $clog2(burst_len_p + 1);

    // Arbitration state and the output register.
    logic [ID_W-1:0]     owner_q, owner_d;
    logic                lock_q, lock_d;
    logic [BURST_W-1:0]  burst_q, burst_d;
    logic                v_q, v_d;
    bsg_fsb_pkt_client_s data_q;

    logic                     load;
    logic [num_clients_p-1:0] elig;
    logic                     keep_owner;
    logic [ID_W-1:0]          rr_start;
    logic [num_clients_p-1:0] pick_oh;
    logic                     pick_v;
    logic [num_clients_p-1:0] grant_oh;
    logic                     grant_v;
    logic [ID_W-1:0]          grant_idx;

    assign load       = ~v_q | yumi_i;
    assign elig       = v_i & en_i;
    // Owner keeps the bus only while it stays eligible and has burst budget left.
    assign keep_owner = lock_q & elig[owner_q] & (burst_q < BURST_W'(burst_len_p));
    assign rr_start   = (owner_q == ID_W'(num_clients_p - 1)) ? '0 : owner_q + ID_W'(1);

    bsg_rocket_fsb_rr_pick #(
        .num_clients_p (num_clients_p)
    ) u_pick (
        .elig_i     (elig),
        .start_i    (rr_start),
        .grant_oh_o (pick_oh),
        .grant_v_o  (pick_v)
    );

    assign grant_oh = keep_owner ? (num_clients_p'(1) << owner_q) : pick_oh;
    assign grant_v  = keep_owner | pick_v;

    // Encode the one-hot grant back to a client index.
    always_comb begin
        grant_idx = '0;
        for (int k = 0; k < num_clients_p; k++) begin
            if (grant_oh[k]) begin
                grant_idx = ID_W'(k);
            end
        end
    end

    // Dequeue is only offered in a load slot and never while in reset.
    assign yumi_o = (load && grant_v && !reset_i) ? grant_oh : '0;

    // Next-state for output valid and owner/lock/burst tracking.
    always_comb begin
        v_d     = v_q;
        owner_d = owner_q;
        lock_d  = lock_q;
        burst_d = burst_q;
        if (load) begin
            if (grant_v) begin
                v_d     = 1'b1;
                owner_d = grant_idx;
                lock_d  = 1'b1;
                // Re-grant after an exhausted burst restarts the count at 1.
                burst_d = keep_owner ? burst_q + BURST_W'(1) : BURST_W'(1);
            end else begin
                v_d     = 1'b0;
                lock_d  = 1'b0;
                burst_d = '0;
            end
        end
    end

    // Control state register; client 0 gets first priority out of reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            v_q     <= 1'b0;
            owner_q <= ID_W'(num_clients_p - 1);
            lock_q  <= 1'b0;
            burst_q <= '0;
        end else begin
            v_q     <= v_d;
            owner_q <= owner_d;
            lock_q  <= lock_d;
            burst_q <= burst_d;
        end
    end

    // Output packet register, loaded from the granted client.
    always_ff @(posedge clk_i) begin
        if (!reset_i && load && grant_v) begin
            data_q <= data_i[grant_idx];
        end
    end

    assign v_o    = v_q;
    assign data_o = data_q;

endmodule : bsg_rocket_fsb_out_arb
`default_nettype wire

// File: tb/tb_bsg_rocket_fsb_out_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_bsg_rocket_fsb_out_arb
// Description : Directed self-checking bench for the FSB output arbiter
//               (two clients, burst length 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bsg_rocket_fsb_out_arb;
    import bsg_fsb_pkg::*;

    localparam int N = 2;

    logic                         clk;
    logic                         reset_i;
    logic [N-1:0]                 en_i;
    logic [N-1:0]                 v_i;
    bsg_fsb_pkt_client_s [N-1:0]  data_i;
    logic [N-1:0]                 yumi_o;
    logic                         v_o;
    bsg_fsb_pkt_client_s          data_o;
    logic                         yumi_i;

    int n_chk = 0;
    int n_bad = 0;

    bsg_rocket_fsb_out_arb #(
        .num_clients_p (N),
        .burst_len_p   (4)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .en_i    (en_i),
        .v_i     (v_i),
        .data_i  (data_i),
        .yumi_o  (yumi_o),
        .v_o     (v_o),
        .data_o  (data_o),
        .yumi_i  (yumi_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bsg_fsb_pkt_client_s mk(input int k, input int s);
        bsg_fsb_pkt_client_s p;
        p.destid = 4'(k);
        p.cmd    = s[0];
        p.data   = (75'(s) << 8) | 75'(k) | (75'h5A << 64);
        return p;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs with every client presenting a packet stamped s.
    task automatic drive(input logic [N-1:0] v, input logic [N-1:0] en, input logic y, input int s);
        v_i    = v;
        en_i   = en;
        yumi_i = y;
        for (int k = 0; k < N; k++) data_i[k] = mk(k, s);
        #4;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int exp_g [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};

    initial begin
        reset_i = 1'b1;
        drive(2'b11, 2'b11, 1'b0, 0);
        tick();
        tick();
        drive(2'b11, 2'b11, 1'b0, 0);
        chk("rst_yumi", 128'(yumi_o), 128'(0));
        chk("rst_v", 128'(v_o), 128'(0));
        tick();
        reset_i = 1'b0;
        drive(2'b00, 2'b11, 1'b0, 0);
        chk("idle_v", 128'(v_o), 128'(0));
        chk("idle_yumi", 128'(yumi_o), 128'(0));
        tick();

        // Single client streaming at full throughput.
        drive(2'b01, 2'b11, 1'b0, 1);
        chk("s0_yumi", 128'(yumi_o), 128'(2'b01));
        chk("s0_v", 128'(v_o), 128'(0));
        tick();
        for (int i = 2; i <= 7; i++) begin
            drive(2'b01, 2'b11, 1'b1, i);
            chk("s0s_yumi", 128'(yumi_o), 128'(2'b01));
            chk("s0s_v", 128'(v_o), 128'(1));
            chk("s0s_data", 128'(data_o), 128'(mk(0, i - 1)));
            tick();
        end
        drive(2'b00, 2'b11, 1'b1, 8);
        chk("drain_yumi", 128'(yumi_o), 128'(0));
        chk("drain_data", 128'(data_o), 128'(mk(0, 7)));
        tick();
        drive(2'b00, 2'b11, 1'b0, 9);
        chk("drain_v", 128'(v_o), 128'(0));
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;

        // Two clients always valid: bursts of four, then rotate.
        for (int c = 0; c < 10; c++) begin
            drive(2'b11, 2'b11, (c > 0), 100 + c);
            chk("rr_yumi", 128'(yumi_o), 128'(2'b01 << exp_g[c]));
            if (c > 0) chk("rr_data", 128'(data_o), 128'(mk(exp_g[c-1], 100 + c - 1)));
            tick();
        end

        // Client 0 disabled mid-burst: client 1 takes over, 0 never granted.
        for (int c = 0; c < 3; c++) begin
            drive(2'b11, 2'b10, 1'b1, 200 + c);
            chk("en_yumi", 128'(yumi_o), 128'(2'b10));
            if (c == 0) chk("en_data", 128'(data_o), 128'(mk(0, 109)));
            else        chk("en_data", 128'(data_o), 128'(mk(1, 200 + c - 1)));
            tick();
        end

        // Downstream stall holds the output and blocks dequeues.
        for (int c = 0; c < 5; c++) begin
            drive(2'b11, 2'b11, 1'b0, 300 + c);
            chk("stall_yumi", 128'(yumi_o), 128'(0));
            chk("stall_v", 128'(v_o), 128'(1));
            chk("stall_data", 128'(data_o), 128'(mk(1, 202)));
            tick();
        end
        drive(2'b11, 2'b11, 1'b1, 310);
        chk("unstall_yumi", 128'(yumi_o), 128'(2'b10));
        tick();
        drive(2'b11, 2'b11, 1'b1, 311);
        chk("rot_yumi", 128'(yumi_o), 128'(2'b01));
        chk("rot_data", 128'(data_o), 128'(mk(1, 310)));
        tick();
        drive(2'b11, 2'b11, 1'b1, 312);
        chk("b2_yumi", 128'(yumi_o), 128'(2'b01));
        tick();

        // Idle load slot clears the lock; rotation resumes after owner 0.
        drive(2'b00, 2'b11, 1'b1, 313);
        chk("gap_yumi", 128'(yumi_o), 128'(0));
        chk("gap_data", 128'(data_o), 128'(mk(0, 312)));
        tick();
        drive(2'b11, 2'b11, 1'b0, 314);
        chk("gap_v", 128'(v_o), 128'(0));
        chk("after_gap_yumi", 128'(yumi_o), 128'(2'b10));
        tick();

        // Reset while holding a packet from client 1.
        reset_i = 1'b1;
        drive(2'b11, 2'b11, 1'b0, 315);
        chk("mid_rst_yumi", 128'(yumi_o), 128'(0));
        chk("pre_rst_data", 128'(data_o), 128'(mk(1, 314)));
        tick();
        reset_i = 1'b0;
        drive(2'b11, 2'b11, 1'b0, 316);
        chk("post_rst_v", 128'(v_o), 128'(0));
        chk("post_rst_yumi", 128'(yumi_o), 128'(2'b01));
        tick();
        drive(2'b00, 2'b11, 1'b1, 317);
        chk("post_rst_v1", 128'(v_o), 128'(1));
        chk("post_rst_data", 128'(data_o), 128'(mk(0, 316)));
        tick();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule : tb_bsg_rocket_fsb_out_arb
`default_nettype wire

// File: doc/bsg_rocket_fsb_out_arb.md
BSG_ROCKET_FSB_OUT_ARB -- requirements
Module: bsg_rocket_fsb_out_arb

Interface
REQ-001 SHALL have parameter num_clients_p, default 2: number of node-client output streams merged; legal range 2..8.
REQ-002 SHALL have parameter burst_len_p, default 4: max consecutive packets one client may send before the grant rotates; legal range 1..15.
REQ-003 SHALL have port clk_i  input  1  the single clock.
REQ-004 SHALL have port reset_i  input  1  synchronous, active-high reset.
REQ-005 SHALL have port en_i  input  num_clients_p  per-client enable; a client with its en_i bit low is never granted.
REQ-006 SHALL have port v_i  input  num_clients_p  per-client packet valid.
REQ-007 SHALL have port data_i  input  num_clients_p x bsg_fsb_pkt_client_s  per-client packet.
REQ-008 SHALL have port yumi_o  output  num_clients_p  per-client dequeue; one-hot or zero.
REQ-009 SHALL have port v_o  output  1  merged output valid.
REQ-010 SHALL have port data_o  output  bsg_fsb_pkt_client_s  merged output packet, driven from a register.
REQ-011 SHALL have port yumi_i  input  1  downstream consume; legal only while v_o=1.

Function
REQ-012 SHALL hold one packet in an output register; v_o/data_o come straight from it, with no combinational path from v_i/data_i.
REQ-013 SHALL define the load slot as (v_o=0) or (yumi_i=1); arbitration happens only in a load slot.
REQ-014 SHALL define client k as eligible when v_i[k] & en_i[k].
REQ-015 SHALL, in a load slot, grant the current owner when lock=1, the owner is eligible and burst_cnt < burst_len_p.
REQ-016 SHALL otherwise grant the first eligible client in round-robin order starting at owner+1 mod num_clients_p.
REQ-017 SHALL, on a grant to g, assert yumi_o[g] combinationally in that cycle, load data_i[g] into the output register and set v_o=1 on the next edge.
REQ-018 SHALL, on a grant, set owner=g and lock=1; burst_cnt becomes burst_cnt+1 if g equals the old owner with lock=1, else 1.
REQ-019 SHALL, in a load slot with no eligible client, clear lock and burst_cnt; v_o becomes 0 if yumi_i=1, and owner is unchanged.
REQ-020 SHALL allow full throughput: yumi_i=1 and a new grant in the same cycle give back-to-back v_o=1 with no bubble.
REQ-021 SHALL hold v_o and data_o stable, and assert no yumi_o, while v_o=1 and yumi_i=0.
REQ-022 SHALL give 1-cycle latency from an accepted v_i to v_o.
REQ-023 SHALL end the owner's lock when its en_i bit drops; REQ-016 then applies.
REQ-024 SHALL size burst_cnt at $clog2(burst_len_p+1) bits, so it never wraps; reaching burst_len_p forces rotation even if only the owner is eligible (the owner may then be re-granted, with burst_cnt restarting at 1).

Reset
REQ-025 SHALL, when reset_i=1 at an edge, set v_o=0, lock=0, burst_cnt=0 and owner=num_clients_p-1, so client 0 has first priority.
REQ-026 SHALL hold yumi_o=0 during reset; an in-flight packet is discarded when reset is asserted mid-operation.

Structure
REQ-027 SHALL take bsg_fsb_pkt_client_s from the shared bsg_fsb_pkg and define no new packet types.
REQ-028 SHALL place the combinational rotating-priority picker in one sub-module, bsg_rocket_fsb_rr_pick (inputs: eligible vector, start index; outputs: grant one-hot, grant valid).
REQ-029 SHALL keep the owner/lock/burst_cnt state in the top module.

Verification
REQ-030 Reset, then only client 0 streaming with yumi_i=1 and burst_len_p=4 -> one packet per cycle, yumi_o=01 every cycle, v_o first high on the cycle after the first v_i.
REQ-031 Clients 0 and 1 both always valid, yumi_i=1, burst_len_p=4 -> grant pattern 0,0,0,0,1,1,1,1,0...
REQ-032 Downstream stall: yumi_i=0 for 5 cycles with v_o=1 -> data_o unchanged and yumi_o=0 throughout; the next grant occurs in the cycle yumi_i returns to 1.
REQ-033 en_i[0] dropped while client 0 owns mid-burst at burst_cnt=2 -> client 1 granted at the next load slot, and client 0 is never granted while disabled.
REQ-034 Client 0 idles one load slot mid-burst -> lock clears, and when both clients are valid again client 1 is granted first.
REQ-035 reset_i asserted for 1 cycle while v_o=1 -> v_o=0 after the edge, and client 0 is granted first after release even if client 1 last owned.
